// File: rtl/risc_bus_pkg.sv
// risc_bus_pkg
//   Shared definitions for the CPU's byte-wide data bus: default address
//   width, the byte-serializer FSM state encoding and the byte-order
//   convention (high byte at the lower address) that both the store side
//   and the capture side must agree on.
package risc_bus_pkg;

  // Default byte address width of the data bus.
  localparam int ADDR_W_DEF = 13;

  // Byte-order convention: the high byte of a 16-bit word lives at the base
  // address, the low byte at base+1.
  localparam int HI_BYTE_OFFSET = 0;
  localparam int LO_BYTE_OFFSET = 1;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } tx_state_e;

  // Byte extraction helpers matching the byte-order convention above.
  function automatic logic [7:0] hi_byte(input logic [15:0] word);
    return word[15:8];
  endfunction

  function automatic logic [7:0] lo_byte(input logic [15:0] word);
    return word[7:0];
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// word_hold_reg
//   One-entry holding register for a 16-bit word plus its byte address.
//   Lets the core hand off the next word while the current one is still
//   being serialized onto the bus.
// Ports:
//   clk, rst     clock / synchronous active-low reset
//   load         capture load_word/load_addr and set full
//   load_word    word to capture
//   load_addr    byte base address to capture
//   take         consumer has copied the contents; clear full
//   full         register holds a word
//   word, addr   held contents
module word_hold_reg #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [15:0]       load_word,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              take,
  output logic              full,
  output logic [15:0]       word,
  output logic [ADDR_W-1:0] addr
);

  logic              full_q, full_d;
  logic [15:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // load only happens when empty and take only when full, so the two are
  // mutually exclusive and need no priority between them.
  always_comb begin
    full_d = full_q;
    word_d = word_q;
    addr_d = addr_q;
    if (load) begin
      full_d = 1'b1;
      word_d = load_word;
      addr_d = load_addr;
    end else if (take) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q <= 1'b0;
      word_q <= '0;
      addr_q <= '0;
    end else begin
      full_q <= full_d;
      word_q <= word_d;
      addr_q <= addr_d;
    end
  end

  assign full = full_q;
  assign word = word_q;
  assign addr = addr_q;

endmodule

// File: rtl/word_byte_tx.sv
// word_byte_tx
//   Byte-serializing store unit. Accepts a 16-bit word and byte base address
//   over a valid/ready handshake and writes it to the 8-bit bus as two byte
//   write cycles: high byte at the base address, then low byte at base+1
//   (wrapping modulo 2^ADDR_W). Each byte is held WAIT_CYC+1 cycles. A
//   one-entry holding register allows back-to-back words with no bus idle.
// Ports:
//   clk, rst        clock / synchronous active-low reset
//   in_valid        core presents a word
//   in_ready        holding register empty
//   in_word         word to store, [15:8] is the high byte
//   in_addr         byte base address
//   bus_data        byte being written (registered)
//   bus_addr        byte address being written (registered)
//   bus_wr          write strobe (registered)
//   busy            a word is held or on the bus
//   done            one-cycle pulse after a word's low byte completes
module word_byte_tx
  import risc_bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_word,
  input  logic [ADDR_W-1:0] in_addr,
  output logic [7:0]        bus_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wr,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

  logic              hold_full;
  logic [15:0]       hold_word;
  logic [ADDR_W-1:0] hold_addr;
  logic              hold_load;
  logic              hold_take;

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        bus_data_q, bus_data_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_wr_q, bus_wr_d;
  logic              done_q, done_d;
  logic              byte_last;
  logic              start_word;

  assign hold_load = in_valid && !hold_full;

  word_hold_reg #(
    .ADDR_W(ADDR_W)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_word(in_word),
    .load_addr(in_addr),
    .take     (hold_take),
    .full     (hold_full),
    .word     (hold_word),
    .addr     (hold_addr)
  );

  assign byte_last = (cnt_q == CNT_W'(WAIT_CYC));

  // Next-state and next-output logic. The bus registers are computed from the
  // state being entered, so bus_* line up with state_q without any
  // combinational path from the inputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    bus_data_d = bus_data_q;
    bus_addr_d = bus_addr_q;
    bus_wr_d   = 1'b0;
    done_d     = 1'b0;
    hold_take  = 1'b0;
    start_word = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full) begin
          start_word = 1'b1;
        end
      end
      HI: begin
        bus_wr_d = 1'b1;
        if (byte_last) begin
          state_d    = LO;
          cnt_d      = '0;
          bus_addr_d = addr_q + ADDR_W'(LO_BYTE_OFFSET);
          bus_data_d = lo_byte(word_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LO: begin
        if (byte_last) begin
          done_d = 1'b1;
          cnt_d  = '0;
          if (hold_full) begin
            start_word = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bus_wr_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Moving a held word onto the bus: shared by IDLE->HI and LO->HI.
    if (start_word) begin
      state_d    = HI;
      cnt_d      = '0;
      hold_take  = 1'b1;
      word_d     = hold_word;
      addr_d     = hold_addr;
      bus_addr_d = hold_addr + ADDR_W'(HI_BYTE_OFFSET);
      bus_data_d = hi_byte(hold_word);
      bus_wr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      bus_data_q <= '0;
      bus_addr_q <= '0;
      bus_wr_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      bus_data_q <= bus_data_d;
      bus_addr_q <= bus_addr_d;
      bus_wr_q   <= bus_wr_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = !hold_full;
  assign busy     = hold_full || (state_q != IDLE);
  assign bus_data = bus_data_q;
  assign bus_addr = bus_addr_q;
  assign bus_wr   = bus_wr_q;
  assign done     = done_q;

endmodule

// File: doc/word_byte_tx.md
# word_byte_tx

Byte-serializing store unit for the CPU's 8-bit data bus. Accepts a 16-bit word plus byte address through a valid/ready handshake and writes it to the bus as two byte write cycles, high byte first at the base address, low byte at base+1. This matches the high-then-low byte order the instruction/data capture side uses when assembling 16-bit words. It sits between the CPU core's store path and the byte-wide memory bus, with a one-entry holding register so the core can hand off the next word while the current one is on the bus.

## Interface
- ADDR_W, 13, bus address width in bits.
- WAIT_CYC, 0, extra cycles each byte write is held on the bus; each byte occupies WAIT_CYC+1 cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  core presents a word.
- in_ready  out  1  holding register empty; a word transfers on a rising edge where in_valid && in_ready.
- in_word  in  16  word to store; [15:8] is the high byte.
- in_addr  in  ADDR_W  byte base address.
- bus_data  out  8  byte being written.
- bus_addr  out  ADDR_W  byte address being written.
- bus_wr  out  1  write strobe.
- busy  out  1  a word is in the holding register or on the bus.
- done  out  1  one-cycle pulse after a word's low byte completes.

## Operation
- Reset (rst=0 at an edge) forces the following:
  - state=IDLE, hold empty, wait counter 0.
  - in_ready=1, bus_wr=0, bus_data=0, bus_addr=0, busy=0, done=0.
- Reset mid-word aborts the word and drops any held word. No further bus writes occur for them.
- Holding register (word, addr, full flag):
  - It loads on handshake and sets full.
  - It clears when the transmit FSM takes its contents.
  - in_ready = !full. Accept and drain never coincide.
- FSM states: IDLE, HI, LO.
  - IDLE to HI when hold is full. The FSM loads word and addr from hold and clears full.
  - HI to LO after WAIT_CYC+1 cycles in HI.
  - LO to HI when LO ends and hold is full. This is a back-to-back word with no idle cycle on the bus.
  - LO to IDLE when LO ends and hold is empty.
- Outputs by state:
  - HI: bus_addr=A, bus_data=word[15:8], bus_wr=1.
  - LO: bus_addr=(A+1) mod 2^ADDR_W, bus_data=word[7:0], bus_wr=1.
  - IDLE: bus_wr=0; bus_data and bus_addr hold their last values.
- Address wrap: base address 2^ADDR_W-1 writes its low byte at address 0.
- The wait counter resets at every byte boundary.
- busy = full || state!=IDLE.
- done is asserted for exactly one cycle, in the cycle after each LO phase ends. This holds whether the next state is IDLE or HI.

## Timing
- All outputs are registered except in_ready and busy, which are decoded from registers. No combinational path from in_* to bus_*.
- Handshake at the edge ending cycle N, FSM in IDLE with hold empty:
  - Cycle N+1: full=1, in_ready=0.
  - Cycle N+2: first HI cycle.
  - Cycles N+2 .. N+2+WAIT_CYC: HI.
  - Next WAIT_CYC+1 cycles: LO.
  - done is high in cycle N+3+2·WAIT_CYC+1.
- Cycle N+2: in_ready=1 again, so a second word can be accepted during HI/LO. It goes on the bus immediately after the first word's LO.
- Sustained throughput is one word per 2·(WAIT_CYC+1) cycles with no bus idle between words.
- in_word and in_addr are sampled only at the handshake edge; later changes have no effect.
- in_valid may drop without a handshake; nothing is captured.

## Structure
- Shared package risc_bus_pkg:
  - ADDR_W default constant.
  - The FSM state enum {IDLE, HI, LO}.
  - The byte-order convention (high byte at the lower address), for reuse by the capture side.
- One natural sub-module, word_hold_reg: the 16+ADDR_W-bit holding register with its full flag and load/take ports.
- The FSM, wait counter and bus output registers stay in the top.

## Test plan
- Reset mid-word: assert rst during the LO phase of a word -> next cycle bus_wr=0, bus_data=0, bus_addr=0, in_ready=1, busy=0; no further bus writes.
- Single word, WAIT_CYC=0: word 16'hA55A at addr 13'h0100 -> bus_wr=1 with (0x0100, 0xA5) in cycle N+2, then (0x0101, 0x5A) in N+3; done=1 in N+4 only; then bus_wr=0.
- Wait states, WAIT_CYC=2: word 16'h1234 at 13'h0010 -> 0x12 held at 0x0010 for 3 cycles, then 0x34 at 0x0011 for 3 cycles; done one cycle after.
- Back-to-back: a second word 16'hBEEF at 13'h0200 accepted during the first word's HI phase -> bus_wr stays 1 continuously across 4 byte cycles in the order 0x0100/0xA5, 0x0101/0x5A, 0x0200/0xBE, 0x0201/0xEF.
- Address wrap: word 16'hC3D4 at 13'h1FFF -> 0xC3 at 0x1FFF, then 0xD4 at 0x0000.
- Backpressure: hold in_valid=1 continuously -> in_ready toggles as specified, each word accepted exactly once, and bus byte order matches input order over 8 random words.
